// File: rtl/seg_pkg.sv
// seg_pkg: active-low 7-segment hex patterns and a pattern -> {err, blank, nibble} decode helper
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [15:0][6:0] SEG_HEX = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  typedef struct packed {
    logic err;
    logic blank;
    logic [3:0] nibble;
  } seg_dec_t;
  function automatic seg_dec_t seg_dec(input logic [6:0] p);
    seg_dec_t r;
    logic b;
    b = (p == SEG_BLANK) || (p == SEG_DASH);
    r = '{err: !b, blank: b, nibble: 4'd0};
    for (int i = 0; i < 16; i++)
      if (p == SEG_HEX[i]) r = '{err: 1'b0, blank: 1'b0, nibble: 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational active-low 7-segment pattern -> hex nibble with blank/err flags
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);
  seg_dec_t d;
  assign d = seg_dec(seg);
  assign nibble = d.nibble;
  assign blank = d.blank;
  assign err = d.err;
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed active-low 7-seg bus and rebuilds the displayed word per scan.
// Define SEG_DP_EN to add dp_n input and dp_mask output (decimal point captured with the segments).
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    clear,
`ifdef SEG_DP_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp_mask,
`endif
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    frame_valid,
  output logic                    glitch
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
`ifdef SEG_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif
  logic [SW-1:0] smp_in, smp_r, smp_p;
  logic [NUM_DIGITS-1:0] an_r, an_p, sel, seen, sh_blank, sh_err;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [CW-1:0] cnt;
  logic idle, single, illegal, same, cap, publish, ill_q;
  logic [3:0] d_nib;
  logic d_blank, d_err;
`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0] sh_dp;
  assign smp_in = {dp_n, seg_n};
`else
  assign smp_in = seg_n;
`endif
  seg_decode u_dec (.seg(smp_r[6:0]), .nibble(d_nib), .blank(d_blank), .err(d_err));
  assign sel = ~an_r;
  assign idle = &an_r;
  assign single = $onehot(sel);
  assign illegal = !idle && !single;
  assign same = {an_r, smp_r} == {an_p, smp_p};
  // counter sits one below threshold while the stable sample is still present: capture exactly once
  assign cap = single && same && cnt == CW'(STABLE_CYCLES - 1);
  assign publish = &seen;
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r <= '1;
      an_p <= '1;
      smp_r <= '1;
      smp_p <= '1;
      cnt <= '0;
      ill_q <= 1'b0;
      glitch <= 1'b0;
      seen <= '0;
      sh_val <= '0;
      sh_blank <= '0;
      sh_err <= '0;
      value <= '0;
      blank_mask <= '0;
      err_mask <= '0;
      frame_valid <= 1'b0;
`ifdef SEG_DP_EN
      sh_dp <= '0;
      dp_mask <= '0;
`endif
    end else begin
      an_r <= an_n;
      an_p <= an_r;
      smp_r <= smp_in;
      smp_p <= smp_r;
      ill_q <= illegal;
      glitch <= illegal && !ill_q;
      frame_valid <= publish && !clear;
      if (clear) begin
        cnt <= '0;
        seen <= '0;
        sh_val <= '0;
        sh_blank <= '0;
        sh_err <= '0;
`ifdef SEG_DP_EN
        sh_dp <= '0;
`endif
      end else begin
        cnt <= (idle || illegal) ? '0 : !same ? CW'(1) : (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);
        seen <= (publish ? '0 : seen) | (cap ? sel : '0);
        if (publish) begin
          value <= sh_val;
          blank_mask <= sh_blank;
          err_mask <= sh_err;
`ifdef SEG_DP_EN
          dp_mask <= sh_dp;
`endif
        end
        for (int i = 0; i < NUM_DIGITS; i++)
          if (cap && sel[i]) begin
            sh_val[4*i+:4] <= d_nib;
            sh_blank[i] <= d_blank;
            sh_err[i] <= d_err;
`ifdef SEG_DP_EN
            sh_dp[i] <= !smp_r[7];
`endif
          end
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans with a frame scoreboard checked on every frame_valid pulse
module tb_seg_scan_decoder;
  typedef struct packed {
    logic [15:0] v;
    logic [3:0] b;
    logic [3:0] e;
  } exp_t;
  localparam logic [6:0] PAT [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [6:0] seg_n = 7'h7f;
  logic [3:0] an_n = 4'hf;
  logic [15:0] value;
  logic [3:0] blank_mask, err_mask;
  logic frame_valid, glitch;
  int n_assert = 0, n_fail = 0, frame_cnt = 0, glitch_cnt = 0;
  exp_t q[$];
`ifdef SEG_DP_EN
  logic [3:0] dp_mask;
`endif
  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .an_n(an_n), .clear(clear),
`ifdef SEG_DP_EN
    .dp_n(1'b1), .dp_mask(dp_mask),
`endif
    .value(value), .blank_mask(blank_mask), .err_mask(err_mask),
    .frame_valid(frame_valid), .glitch(glitch)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (glitch) glitch_cnt++;
    if (frame_valid) begin
      frame_cnt++;
      if (q.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("frame_value", 32'(value), 32'(e.v));
        chk("frame_blank", 32'(blank_mask), 32'(e.b));
        chk("frame_err", 32'(err_mask), 32'(e.e));
      end
    end
  end
  task automatic drive(input int k, input logic [6:0] pat, input int hold);
    an_n = ~(4'b0001 << k);
    seg_n = pat;
    repeat (hold) @(negedge clk);
    an_n = 4'hf;
    seg_n = 7'h7f;
    @(negedge clk);
  endtask
  task automatic scan(input logic [6:0] p0, p1, p2, p3);
    drive(0, p0, 6);
    drive(1, p1, 6);
    drive(2, p2, 6);
    drive(3, p3, 6);
    repeat (4) @(negedge clk);
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) begin
      an_n = 4'($urandom);
      seg_n = 7'($urandom);
      @(negedge clk);
    end
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_blank", 32'(blank_mask), 32'h0);
    chk("rst_err", 32'(err_mask), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_glitch", 32'(glitch), 32'h0);
    an_n = 4'hf;
    seg_n = 7'h7f;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q.push_back('{v: 16'hA321, b: 4'h0, e: 4'h0});
    scan(PAT[1], PAT[2], PAT[3], PAT[10]);
    chk("frames_after_scan1", 32'(frame_cnt), 32'd1);
    drive(0, PAT[5], 6);
    drive(1, PAT[6], 6);
    drive(2, PAT[7], 3);
    drive(3, PAT[9], 6);
    repeat (4) @(negedge clk);
    chk("frames_after_short_digit", 32'(frame_cnt), 32'd1);
    q.push_back('{v: 16'h9321, b: 4'h0, e: 4'h0});
    scan(PAT[1], PAT[2], PAT[3], PAT[10]);
    chk("frames_after_rescan", 32'(frame_cnt), 32'd2);
    pulse_clear();
    q.push_back('{v: 16'h0054, b: 4'b1000, e: 4'b0100});
    scan(PAT[4], PAT[5], 7'b1111110, 7'b1111111);
    an_n = 4'b0011;
    seg_n = PAT[8];
    repeat (2) @(negedge clk);
    an_n = 4'hf;
    seg_n = 7'h7f;
    repeat (3) @(negedge clk);
    chk("glitch_pulses", 32'(glitch_cnt), 32'd1);
    chk("frames_after_glitch", 32'(frame_cnt), 32'd3);
    q.push_back('{v: 16'hBA98, b: 4'h0, e: 4'h0});
    scan(PAT[8], PAT[9], PAT[10], PAT[11]);
    drive(0, PAT[12], 6);
    drive(1, PAT[13], 6);
    drive(2, PAT[14], 6);
    pulse_clear();
    q.push_back('{v: 16'h7654, b: 4'h0, e: 4'h0});
    scan(PAT[4], PAT[5], PAT[6], PAT[7]);
    drive(0, PAT[1], 6);
    drive(1, PAT[1], 6);
    drive(2, PAT[1], 6);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_reset_value", 32'(value), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    q.push_back('{v: 16'h7654, b: 4'h0, e: 4'h0});
    scan(PAT[4], PAT[5], PAT[6], PAT[7]);
    repeat (10) @(negedge clk);
    chk("value_held", 32'(value), 32'h7654);
    chk("frames_total", 32'(frame_cnt), 32'd6);
    chk("glitch_total", 32'(glitch_cnt), 32'd1);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
